// File: rtl/matmul_lane_engine.sv
// matmul_lane_engine: C = A*B with LANES parallel MAC lanes feeding a row-major output FIFO.
// Build option MATMUL_SAT_EN: saturating, sticky accumulation instead of two's-complement wrap.
module matmul_lane_engine #(
  parameter int N           = 8,
  parameter int P           = 9,
  parameter int M           = 10,
  parameter int LANES       = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int ACCUM_WIDTH = 2*DATA_WIDTH + $clog2(P),
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [LANES*DATA_WIDTH-1:0]     in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [ACCUM_WIDTH-1:0]          out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);
  localparam int GROUPS = M / LANES;
  localparam int KW     = (P > 1) ? $clog2(P) : 1;
  localparam int NW     = (N > 1) ? $clog2(N) : 1;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH+1);
  localparam int MW     = 2*DATA_WIDTH;
  localparam int AW1    = ACCUM_WIDTH + 1;

  localparam logic [KW-1:0] K_LAST   = KW'(P-1);
  localparam logic [NW-1:0] N_LAST   = NW'(N-1);
  localparam logic [GW-1:0] G_LAST   = GW'(GROUPS-1);
  localparam logic [LW-1:0] L_LAST   = LW'(LANES-1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH-1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  if (M % LANES != 0) begin : g_bad_m
    $error("matmul_lane_engine: M must be a multiple of LANES");
  end

  typedef enum logic [2:0] {IDLE, LOAD_ROW, STREAM_COL, DRAIN, DONE} state_t;
  state_t state;

  logic [KW-1:0]                 k;
  logic [NW-1:0]                 n;
  logic [GW-1:0]                 g;
  logic [LW-1:0]                 lane;
  logic signed [DATA_WIDTH-1:0]  row     [P];
  logic signed [ACCUM_WIDTH-1:0] acc     [LANES];
  logic signed [ACCUM_WIDTH-1:0] acc_nxt [LANES];
  logic signed [ACCUM_WIDTH-1:0] mem     [FIFO_DEPTH];
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic                          push, pop, first_beat;

  // Exact (one bit wider) sum of the running value and a full-width signed product.
  function automatic logic signed [ACCUM_WIDTH:0] mac_sum(
    input logic signed [ACCUM_WIDTH-1:0] base,
    input logic signed [DATA_WIDTH-1:0]  a,
    input logic signed [DATA_WIDTH-1:0]  b
  );
    logic signed [MW-1:0] prod;
    prod = MW'(a) * MW'(b);
    return AW1'(base) + AW1'(prod);
  endfunction

`ifdef MATMUL_SAT_EN
  localparam logic signed [ACCUM_WIDTH-1:0] ACC_MAX = {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
  localparam logic signed [ACCUM_WIDTH-1:0] ACC_MIN = {1'b1, {(ACCUM_WIDTH-1){1'b0}}};
  logic [LANES-1:0]            sat, sat_nxt;
  logic signed [ACCUM_WIDTH:0] sum_l;

  function automatic logic sum_overflows(input logic signed [ACCUM_WIDTH:0] s);
    return s[ACCUM_WIDTH] != s[ACCUM_WIDTH-1];
  endfunction

  function automatic logic signed [ACCUM_WIDTH-1:0] saturate(input logic signed [ACCUM_WIDTH:0] s);
    if (sum_overflows(s)) return s[ACCUM_WIDTH] ? ACC_MIN : ACC_MAX;
    return s[ACCUM_WIDTH-1:0];
  endfunction
`endif

  assign first_beat = (k == '0);

  always_comb begin
    acc_nxt = acc;
`ifdef MATMUL_SAT_EN
    sat_nxt = '0;
    sum_l   = '0;
`endif
    for (int l = 0; l < LANES; l++) begin
`ifdef MATMUL_SAT_EN
      sum_l = mac_sum(first_beat ? '0 : acc[l], row[k],
                      $signed(in_data[l*DATA_WIDTH +: DATA_WIDTH]));
      // A lane that clipped earlier in this element keeps its clamp value.
      if (!first_beat && sat[l]) begin
        acc_nxt[l] = acc[l];
        sat_nxt[l] = 1'b1;
      end else begin
        acc_nxt[l] = saturate(sum_l);
        sat_nxt[l] = sum_overflows(sum_l);
      end
`else
      acc_nxt[l] = ACCUM_WIDTH'(mac_sum(first_beat ? '0 : acc[l], row[k],
                                        $signed(in_data[l*DATA_WIDTH +: DATA_WIDTH])));
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      k        <= '0;
      n        <= '0;
      g        <= '0;
      lane     <= '0;
      for (int i = 0; i < P; i++) row[i] <= '0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
`ifdef MATMUL_SAT_EN
      sat      <= '0;
`endif
    end else begin
      if (start && busy) err <= 1'b1;
      case (state)
        IDLE, DONE: if (start) begin
          state    <= LOAD_ROW;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b0;
          n        <= '0;
          g        <= '0;
          k        <= '0;
        end
        LOAD_ROW: if (in_valid) begin
          row[k] <= $signed(in_data[DATA_WIDTH-1:0]);
          if (k == K_LAST) begin
            k     <= '0;
            state <= STREAM_COL;
          end else begin
            k <= k + 1'b1;
          end
        end
        STREAM_COL: if (in_valid) begin
          acc <= acc_nxt;
`ifdef MATMUL_SAT_EN
          sat <= sat_nxt;
`endif
          if (k == K_LAST) begin
            k        <= '0;
            lane     <= '0;
            state    <= DRAIN;
            in_ready <= 1'b0;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: if (push) begin
          if (lane == L_LAST) begin
            lane <= '0;
            if (g != G_LAST) begin
              g        <= g + 1'b1;
              state    <= STREAM_COL;
              in_ready <= 1'b1;
            end else if (n != N_LAST) begin
              n        <= n + 1'b1;
              g        <= '0;
              state    <= LOAD_ROW;
              in_ready <= 1'b1;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            lane <= lane + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output FIFO: push decided on the pre-pop occupancy, pointers wrap at FIFO_DEPTH.
  assign push      = (state == DRAIN) && (fifo_count < DEPTH_C);
  assign pop       = out_ready && (fifo_count != '0);
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= acc[lane];
  end
endmodule

// File: tb/tb_matmul_lane_engine.sv
// Self-checking bench for matmul_lane_engine: reference C = A*B model, scoreboard on every pop,
// directed cases (basic, back-pressure, stall, busy start, mid-run reset, overflow) plus random jobs.
module tb_matmul_lane_engine;
  localparam int N = 2, P = 3, M = 4, LANES = 2, DW = 16, AW = 32, FD = 4;
  localparam int CW = $clog2(FD+1);
`ifdef MATMUL_SAT_EN
  localparam longint ACC_MAX = (longint'(1) <<< (AW-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (AW-1));
  localparam longint OVF_EXP = 2147483647;
`else
  localparam longint OVF_EXP = -1073938429;
`endif

  logic                clk = 1'b0;
  logic                rst_n, start, in_valid, in_ready, out_valid, out_ready, busy, done, err;
  logic [LANES*DW-1:0] in_data;
  logic [AW-1:0]       out_data;
  logic [CW-1:0]       fifo_count;

  int     pass_cnt = 0, total_cnt = 0, cyc = 0;
  int     ready_mode = 1;
  bit     abort = 0;
  int     A [N][P];
  int     B [P][M];
  longint exp_q [$];
  longint got_q [$];
  int     lit [8] = '{4, 5, 8, 3, 10, 11, 23, 6};

  matmul_lane_engine #(
    .N(N), .P(P), .M(M), .LANES(LANES), .DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint got, input longint exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference element: plain dot product with the accumulator's overflow rule.
  function automatic longint model_elem(input int r, input int c);
    longint acc = 0;
    longint prod;
    bit     clipped = 0;
    for (int kk = 0; kk < P; kk++) begin
      prod = longint'(A[r][kk]) * longint'(B[kk][c]);
`ifdef MATMUL_SAT_EN
      if (!clipped) begin
        acc = acc + prod;
        if (acc > ACC_MAX) begin acc = ACC_MAX; clipped = 1; end
        else if (acc < ACC_MIN) begin acc = ACC_MIN; clipped = 1; end
      end
`else
      acc = acc + prod;
`endif
    end
    return longint'($signed(acc[AW-1:0]));
  endfunction

  task automatic load_expected();
    exp_q.delete();
    got_q.delete();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++) exp_q.push_back(model_elem(r, c));
  endtask

  task automatic set_basic();
    A = '{'{1, 2, 3}, '{4, 5, 6}};
    B = '{'{1, 0, 2, -1}, '{0, 1, 3, 2}, '{1, 1, 0, 0}};
  endtask

  // Scoreboard: drives out_ready and checks every popped element in order.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (rst_n && out_valid && out_ready) begin
        got_q.push_back(longint'($signed(out_data)));
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL extra_output: got %0d, expected no further output", $signed(out_data));
        end else begin
          check("out_data", longint'($signed(out_data)), exp_q.pop_front());
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // smode: 0 = always valid, 1 = valid toggles every cycle, 2 = random valid.
  task automatic drive_run(input int smode);
    logic [LANES*DW-1:0] beats [$];
    logic [LANES*DW-1:0] b;
    int idx = 0, budget = 3000;
    bit tog = 0;
    for (int r = 0; r < N; r++) begin
      for (int kk = 0; kk < P; kk++) begin
        b = 32'($urandom);
        b[DW-1:0] = DW'(A[r][kk]);
        beats.push_back(b);
      end
      for (int gg = 0; gg < M/LANES; gg++)
        for (int kk = 0; kk < P; kk++) begin
          for (int l = 0; l < LANES; l++) b[l*DW +: DW] = DW'(B[kk][gg*LANES+l]);
          beats.push_back(b);
        end
    end
    while (idx < beats.size() && budget > 0 && !abort) begin
      case (smode)
        0:       in_valid = 1'b1;
        1:       begin in_valid = tog; tog = !tog; end
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? beats[idx] : 32'($urandom);
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      budget--;
    end
    in_valid = 1'b0;
    if (budget == 0) begin
      total_cnt++;
      $display("FAIL drive_beats: only %0d of %0d beats accepted, expected all", idx, beats.size());
    end
  endtask

  task automatic wait_done(output int done_cyc);
    int b = 0;
    while (!done && b < 3000) begin @(negedge clk); b++; end
    check("done", done, 1);
    done_cyc = cyc;
    b = 0;
    while (exp_q.size() != 0 && b < 3000) begin @(negedge clk); b++; end
    check("outputs_remaining", exp_q.size(), 0);
  endtask

  task automatic run_job(input int smode, output int cycles);
    int t0, t1;
    load_expected();
    pulse_start();
    t0 = cyc;
    drive_run(smode);
    wait_done(t1);
    cycles = t1 - t0;
  endtask

  task automatic check_basic_seq(input string name);
    check({name, "_count"}, got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check(name, got_q[i], lit[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_fifo_count"}, fifo_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    int basic_cyc, stall_cyc, dummy, b;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic product, with the model pinned against hand-computed values.
    set_basic();
    load_expected();
    for (int i = 0; i < 8; i++) check("model_pin", exp_q[i], lit[i]);
    pulse_start();
    check("in_ready_after_start", in_ready, 1);
    check("busy_after_start", busy, 1);
    begin
      int t0 = cyc;
      drive_run(0);
      wait_done(basic_cyc);
      basic_cyc = basic_cyc - t0;
    end
    check("basic_busy", busy, 0);
    check("basic_err", err, 0);
    check_basic_seq("basic_seq");

    // Input stall: valid toggles every cycle.
    run_job(1, stall_cyc);
    check_basic_seq("stall_seq");
    check("stall_run_longer", stall_cyc > basic_cyc + 10, 1);

    // Start while busy, issued during STREAM_COL of the first row.
    load_expected();
    pulse_start();
    fork
      drive_run(0);
      begin
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_on_busy_start", err, 1);
        check("busy_kept", busy, 1);
      end
    join
    wait_done(dummy);
    check("err_sticky_at_done", err, 1);
    check_basic_seq("busy_start_seq");

    // Back-pressure: consumer stalled until the FIFO is full and the engine holds in DRAIN.
    ready_mode = 0;
    load_expected();
    pulse_start();
    check("err_cleared_by_start", err, 0);
    check("done_cleared_by_start", done, 0);
    fork
      drive_run(0);
      begin
        b = 0;
        while (!(fifo_count == CW'(FD) && !in_ready) && b < 500) begin @(negedge clk); b++; end
        repeat (5) @(negedge clk);
        check("bp_fifo_full", fifo_count, FD);
        check("bp_in_ready", in_ready, 0);
        check("bp_busy", busy, 1);
        check("bp_out_valid", out_valid, 1);
        ready_mode = 1;
      end
    join
    wait_done(dummy);
    check_basic_seq("bp_seq");

    // Asynchronous reset in DRAIN with two elements queued, then a clean restart.
    ready_mode = 0;
    load_expected();
    pulse_start();
    fork
      drive_run(0);
      begin
        b = 0;
        while (!(fifo_count == CW'(2) && !in_ready && busy) && b < 500) begin @(negedge clk); b++; end
        rst_n = 1'b0;
        abort = 1;
        #1;
        check_reset_outputs("midrun_reset");
      end
    join
    exp_q.delete();
    got_q.delete();
    @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    abort = 0;
    ready_mode = 1;
    @(negedge clk);
    run_job(0, dummy);
    check_basic_seq("after_reset_seq");

    // Overflow: every operand at the positive limit.
    for (int r = 0; r < N; r++) for (int c = 0; c < P; c++) A[r][c] = 32767;
    for (int r = 0; r < P; r++) for (int c = 0; c < M; c++) B[r][c] = 32767;
    check("model_ovf_pin", model_elem(0, 0), OVF_EXP);
    run_job(0, dummy);
    check("ovf_first", (got_q.size() > 0) ? got_q[0] : 0, OVF_EXP);
    check("ovf_last", (got_q.size() > 0) ? got_q[got_q.size()-1] : 0, OVF_EXP);

    // Random operands, random input stalls and random consumer back-pressure.
    ready_mode = 2;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < P; j++) A[i][j] = int'($signed(16'($urandom)));
      for (int i = 0; i < P; i++)
        for (int j = 0; j < M; j++) B[i][j] = int'($signed(16'($urandom)));
      run_job(2, dummy);
    end
    check("final_busy", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
